// File: rtl/fixed_point_accumulator.sv
// ----------------------------------------------------------------------------
// fixed_point_accumulator : frame accumulator that sequences a fixed-point adder
// Revision : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fixed_point_accumulator #(
  parameter int WIDTH = 8,
  parameter int FBITS = 4,
  parameter int COUNT = 4,
  parameter int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sample_valid,
  output logic             o_sample_ready,
  input  logic [WIDTH-1:0] i_sample,
  output logic             o_add_start,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  input  logic             i_add_busy,
  input  logic             i_add_done,
  input  logic             i_add_valid,
  input  logic             i_add_overflow,
  input  logic [WIDTH-1:0] i_add_val,
  output logic             o_acc_valid,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_sat,
  output logic             o_busy
);

  generate
    if (COUNT < 1 || FBITS >= WIDTH) begin : g_param_check
      $error("fixed_point_accumulator: COUNT must be >= 1 and FBITS < WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] C_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ADD  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat_sticky;

  logic             w_done;
  logic             w_last;
  logic [WIDTH-1:0] w_next_acc;
  logic             w_unused;

  // The adder's busy flag is informational; issue is never gated on it.
  assign w_unused = i_add_busy;

  // Done is ignored in the start cycle so a stale pulse cannot complete the add.
  assign w_done = (r_state == S_ADD) && !o_add_start && i_add_done;
  assign w_last = (r_cnt == CNT_W'(COUNT - 1));

  always_comb begin
    w_next_acc = r_acc;
    if (i_add_overflow)
      w_next_acc = o_add_a[WIDTH-1] ? C_NEG_MAX : C_POS_MAX;
    else if (i_add_valid)
      w_next_acc = i_add_val;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_WAIT;
      r_acc          <= '0;
      r_cnt          <= '0;
      r_sat_sticky   <= 1'b0;
      o_add_a        <= '0;
      o_add_b        <= '0;
      o_acc          <= '0;
      o_add_start    <= 1'b0;
      o_acc_valid    <= 1'b0;
      o_sat          <= 1'b0;
      o_sample_ready <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_add_start <= 1'b0;
      o_acc_valid <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (i_sample_valid && o_sample_ready) begin
            o_add_a        <= r_acc;
            o_add_b        <= i_sample;
            o_add_start    <= 1'b1;
            o_sample_ready <= 1'b0;
            o_busy         <= 1'b1;
            r_state        <= S_ADD;
          end else begin
            o_sample_ready <= 1'b1;
          end
        end
        S_ADD: begin
          if (w_done) begin
            r_acc <= w_next_acc;
            r_cnt <= r_cnt + 1'b1;
            if (i_add_overflow)
              r_sat_sticky <= 1'b1;
            if (w_last) begin
              // Final result is presented while S_OUT is the current state.
              o_acc_valid <= 1'b1;
              o_acc       <= w_next_acc;
              o_sat       <= r_sat_sticky | i_add_overflow;
              r_state     <= S_OUT;
            end else begin
              o_sample_ready <= 1'b1;
              o_busy         <= 1'b0;
              r_state        <= S_WAIT;
            end
          end
        end
        S_OUT: begin
          r_acc          <= '0;
          r_cnt          <= '0;
          r_sat_sticky   <= 1'b0;
          o_sample_ready <= 1'b1;
          o_busy         <= 1'b0;
          r_state        <= S_WAIT;
        end
        default: begin
          o_sample_ready <= 1'b0;
          o_busy         <= 1'b0;
          r_state        <= S_WAIT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_accumulator.sv
// ----------------------------------------------------------------------------
// tb_fixed_point_accumulator : directed bench with a behavioural adder model
// Revision : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fixed_point_accumulator;

  localparam int WIDTH = 8;
  localparam int FBITS = 4;
  localparam int COUNT = 4;
  localparam int LAT   = 2;

  typedef logic [WIDTH-1:0] frame_t [COUNT];
  typedef struct {
    frame_t           s;
    logic [WIDTH-1:0] acc;
    logic             sat;
  } vec_t;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_sample_valid = 1'b0;
  logic [WIDTH-1:0] i_sample = '0;
  logic             o_sample_ready;
  logic             o_add_start;
  logic [WIDTH-1:0] o_add_a;
  logic [WIDTH-1:0] o_add_b;
  logic             i_add_busy;
  logic             i_add_done;
  logic             i_add_valid;
  logic             i_add_overflow;
  logic [WIDTH-1:0] i_add_val;
  logic             o_acc_valid;
  logic [WIDTH-1:0] o_acc;
  logic             o_sat;
  logic             o_busy;

  always #5 i_clk = ~i_clk;

  fixed_point_accumulator #(.WIDTH(WIDTH), .FBITS(FBITS), .COUNT(COUNT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_sample_valid(i_sample_valid), .o_sample_ready(o_sample_ready), .i_sample(i_sample),
    .o_add_start(o_add_start), .o_add_a(o_add_a), .o_add_b(o_add_b),
    .i_add_busy(i_add_busy), .i_add_done(i_add_done), .i_add_valid(i_add_valid),
    .i_add_overflow(i_add_overflow), .i_add_val(i_add_val),
    .o_acc_valid(o_acc_valid), .o_acc(o_acc), .o_sat(o_sat), .o_busy(o_busy)
  );

  // Behavioural adder: wrap-around sum, signed overflow flag, LAT-cycle latency.
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_val = '0;
  logic             m_done = 1'b0, m_ovf = 1'b0;
  logic [3:0]       m_cnt = '0;
  logic [WIDTH-1:0] m_sum;
  logic             m_sum_ovf;
  logic             stray = 1'b0;

  assign m_sum     = m_a + m_b;
  assign m_sum_ovf = (m_a[WIDTH-1] == m_b[WIDTH-1]) && (m_sum[WIDTH-1] != m_a[WIDTH-1]);

  always @(posedge i_clk) begin
    m_done <= 1'b0;
    if (o_add_start) begin
      m_a   <= o_add_a;
      m_b   <= o_add_b;
      m_cnt <= 4'(LAT);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1'b1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_ovf  <= m_sum_ovf;
        m_val  <= m_sum;
      end
    end
  end

  assign i_add_busy     = (m_cnt != 0);
  assign i_add_done     = m_done | stray;
  assign i_add_valid    = (m_done & ~m_ovf) | stray;
  assign i_add_overflow = m_done & m_ovf;
  assign i_add_val      = stray ? 8'h55 : m_val;

  // Event monitor
  int               start_total = 0;
  int               accv_total  = 0;
  logic [WIDTH-1:0] cap_acc = '0;
  logic             cap_sat = 1'b0;

  always @(negedge i_clk) begin
    if (o_add_start) start_total <= start_total + 1;
    if (o_acc_valid) begin
      accv_total <= accv_total + 1;
      cap_acc    <= o_acc;
      cap_sat    <= o_sat;
    end
  end

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic send_sample(input logic [WIDTH-1:0] s);
    int n = 0;
    i_sample_valid = 1'b1;
    i_sample       = s;
    while (!o_sample_ready && n < 100) begin
      tick();
      n++;
    end
    if (!o_sample_ready) begin
      check("ready_timeout", {31'd0, o_sample_ready}, 32'd1);
      i_sample_valid = 1'b0;
      return;
    end
    tick();
    i_sample_valid = 1'b0;
    check("add_start", {31'd0, o_add_start}, 32'd1);
    check("add_b", {24'd0, o_add_b}, {24'd0, s});
  endtask

  task automatic run_frame(input frame_t s, input logic [WIDTH-1:0] eacc, input logic esat,
                           input string tag);
    int a0 = accv_total;
    int s0 = start_total;
    int n  = 0;
    for (int i = 0; i < COUNT; i++) send_sample(s[i]);
    while (accv_total == a0 && n < 100) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({tag, ".valid_pulses"}, accv_total - a0, 32'd1);
    check({tag, ".starts"}, start_total - s0, COUNT);
    check({tag, ".acc"}, {24'd0, cap_acc}, {24'd0, eacc});
    check({tag, ".sat"}, {31'd0, cap_sat}, {31'd0, esat});
    check({tag, ".acc_held"}, {24'd0, o_acc}, {24'd0, eacc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int a0, s0, nacc, n, sum;
    logic [WIDTH-1:0] last_acc, smp;

    vecs[0] = '{s: '{8'h10, 8'h10, 8'h10, 8'h10}, acc: 8'h40, sat: 1'b0};
    vecs[1] = '{s: '{8'h70, 8'h70, 8'hF0, 8'h00}, acc: 8'h6F, sat: 1'b1};
    vecs[2] = '{s: '{8'h90, 8'h90, 8'h00, 8'h00}, acc: 8'h80, sat: 1'b1};
    vecs[3] = '{s: '{8'h01, 8'h01, 8'h01, 8'h01}, acc: 8'h04, sat: 1'b0};
    vecs[4] = '{s: '{8'hF0, 8'hF0, 8'hF0, 8'hF0}, acc: 8'hC0, sat: 1'b0};
    vecs[5] = '{s: '{8'h7F, 8'h01, 8'hFF, 8'h00}, acc: 8'h7E, sat: 1'b1};

    // Reset state
    #1;
    check("rst.ready", {31'd0, o_sample_ready}, 32'd0);
    check("rst.add_start", {31'd0, o_add_start}, 32'd0);
    check("rst.acc_valid", {31'd0, o_acc_valid}, 32'd0);
    check("rst.busy", {31'd0, o_busy}, 32'd0);
    check("rst.acc", {24'd0, o_acc}, 32'd0);
    check("rst.sat", {31'd0, o_sat}, 32'd0);
    check("rst.add_a", {24'd0, o_add_a}, 32'd0);
    check("rst.add_b", {24'd0, o_add_b}, 32'd0);
    repeat (2) tick();
    i_rst = 1'b0;
    check("rel.ready_low", {31'd0, o_sample_ready}, 32'd0);
    @(posedge i_clk);
    #1;
    check("rel.ready_high", {31'd0, o_sample_ready}, 32'd1);
    tick();

    for (int v = 0; v < 6; v++)
      run_frame(vecs[v].s, vecs[v].acc, vecs[v].sat, $sformatf("vec%0d", v));

    // Stray done while idle must not disturb the sum or emit a result.
    a0 = accv_total;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (3) tick();
    check("stray.no_valid", accv_total - a0, 32'd0);
    check("stray.busy", {31'd0, o_busy}, 32'd0);
    run_frame('{8'h01, 8'h01, 8'h01, 8'h01}, 8'h04, 1'b0, "after_stray");

    // Backpressure: valid held high, sample changes every cycle.
    a0 = accv_total;
    s0 = start_total;
    nacc = 0;
    sum = 0;
    n = 0;
    last_acc = '0;
    smp = 8'h01;
    i_sample = smp;
    i_sample_valid = 1'b1;
    while (accv_total == a0 && n < 200) begin
      if (o_add_start)
        check("bp.add_b", {24'd0, o_add_b}, {24'd0, last_acc});
      if (o_sample_ready) begin
        last_acc = i_sample;
        nacc++;
        sum += int'(i_sample);
      end
      tick();
      n++;
      smp = (smp + 8'h01) & 8'h0F;
      i_sample = smp;
    end
    i_sample_valid = 1'b0;
    repeat (4) tick();
    check("bp.accepts", nacc, COUNT);
    check("bp.starts", start_total - s0, COUNT);
    check("bp.valid_pulses", accv_total - a0, 32'd1);
    check("bp.acc", {24'd0, cap_acc}, sum & 32'hFF);
    check("bp.sat", {31'd0, cap_sat}, 32'd0);

    // Reset during the add of the third sample.
    a0 = accv_total;
    send_sample(8'h08);
    send_sample(8'h08);
    send_sample(8'h08);
    #1;
    i_rst = 1'b1;
    #1;
    check("midrst.add_start", {31'd0, o_add_start}, 32'd0);
    check("midrst.busy", {31'd0, o_busy}, 32'd0);
    check("midrst.ready", {31'd0, o_sample_ready}, 32'd0);
    check("midrst.add_a", {24'd0, o_add_a}, 32'd0);
    check("midrst.add_b", {24'd0, o_add_b}, 32'd0);
    check("midrst.acc", {24'd0, o_acc}, 32'd0);
    repeat (2) tick();
    i_rst = 1'b0;
    repeat (6) tick();
    check("midrst.no_valid", accv_total - a0, 32'd0);
    run_frame('{8'h08, 8'h08, 8'h08, 8'h08}, 8'h20, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
